// File: rtl/frame_seq_ctrl_if.sv
// Stream and core-monitor signals for the frame sequencer.
// The slave modport is the sequencer's view: it accepts the upstream
// pixel stream, forwards it to the core, and watches the core output.
// The master modport is the surrounding environment's view.
interface frame_seq_ctrl_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       core_out_valid;
    logic       core_out_ready;
    logic       core_out_last;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        output core_out_valid, core_out_ready, core_out_last,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        input  core_out_valid, core_out_ready, core_out_last,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// Frame-level sequencer: gates the pixel stream one frame at a time,
// generates the frame-end last, applies shadowed coefficients/thresholds
// only between frames, and waits for the core's output last (with a
// timeout) before reporting frame completion.
module frame_seq_ctrl #(
    parameter int IMG_W         = 1024,
    parameter int IMG_H         = 1025,
    parameter int DRAIN_TIMEOUT = 65536,
    parameter int FCNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_wr,
    input  logic [7:0]        cfg_coe_00,
    input  logic [7:0]        cfg_coe_01,
    input  logic [7:0]        cfg_coe_02,
    input  logic [7:0]        cfg_coe_11,
    input  logic [7:0]        cfg_coe_12,
    input  logic [7:0]        cfg_coe_22,
    input  logic [7:0]        cfg_gth,
    input  logic [7:0]        cfg_gtl,
    frame_seq_ctrl_if.slave   bus,
    output logic [7:0]        coe_00_out,
    output logic [7:0]        coe_01_out,
    output logic [7:0]        coe_02_out,
    output logic [7:0]        coe_11_out,
    output logic [7:0]        coe_12_out,
    output logic [7:0]        coe_22_out,
    output logic [7:0]        gth_out,
    output logic [7:0]        gtl_out,
    output logic              busy,
    output logic              cfg_pending,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_short,
    output logic              err_long,
    output logic              err_timeout,
    output logic              cfg_err
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] coe_00;
        logic [7:0] coe_01;
        logic [7:0] coe_02;
        logic [7:0] coe_11;
        logic [7:0] coe_12;
        logic [7:0] coe_22;
        logic [7:0] gth;
        logic [7:0] gtl;
    } cfg_t;

    localparam cfg_t CFG_RESET = {8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'd5, 8'd1};

    state_t           state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TO_W-1:0]  to_cnt;
    cfg_t             shadow, active, wr_cfg;
    logic             beat, at_end, core_hs, to_end, load_go, cfg_ok, cfg_bad;

    assign at_end  = (col == COL_LAST) && (row == ROW_LAST);
    assign beat    = (state == STREAM) && bus.s_valid && bus.m_ready;
    assign core_hs = bus.core_out_valid && bus.core_out_ready && bus.core_out_last;
    assign to_end  = (to_cnt == TO_LAST);
    assign load_go = (state == LOAD) && !abort;
    assign cfg_ok  = cfg_wr && (cfg_gth >= cfg_gtl);
    assign cfg_bad = cfg_wr && (cfg_gth < cfg_gtl);
    assign wr_cfg  = {cfg_coe_00, cfg_coe_01, cfg_coe_02, cfg_coe_11,
                      cfg_coe_12, cfg_coe_22, cfg_gth, cfg_gtl};

    assign bus.m_data = bus.s_data;
    assign busy       = (state != IDLE);

    assign coe_00_out = active.coe_00;
    assign coe_01_out = active.coe_01;
    assign coe_02_out = active.coe_02;
    assign coe_11_out = active.coe_11;
    assign coe_12_out = active.coe_12;
    assign coe_22_out = active.coe_22;
    assign gth_out    = active.gth;
    assign gtl_out    = active.gtl;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and stream gating; abort overrides every transition.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nxt   = state;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD:   state_nxt = STREAM;
            STREAM: begin
                bus.s_ready = bus.m_ready;
                bus.m_valid = bus.s_valid;
                bus.m_last  = bus.s_valid && (at_end || bus.s_last);
                if (beat && (at_end || bus.s_last)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (core_hs)     state_nxt = DONE;
                else if (to_end) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Column/row beat position and drain timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            to_cnt <= '0;
        end else begin
            if (abort || state == LOAD) begin
                col <= '0;
                row <= '0;
            end else if (beat) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (abort || state != DRAIN) to_cnt <= '0;
            else                          to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Shadow config accepts validated writes; active copy only moves in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= CFG_RESET;
            active      <= CFG_RESET;
            cfg_pending <= 1'b0;
        end else begin
            if (load_go && cfg_pending) active <= shadow;
            if (cfg_ok) begin
                shadow      <= wr_cfg;
                cfg_pending <= 1'b1;
            end else if (load_go) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    // Sticky error flags: a new event wins over the clear at LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_timeout <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (beat && bus.s_last && !at_end && !abort) err_short <= 1'b1;
            else if (load_go)                            err_short <= 1'b0;
            if (beat && at_end && !bus.s_last && !abort) err_long <= 1'b1;
            else if (load_go)                            err_long <= 1'b0;
            if (state == DRAIN && !core_hs && to_end && !abort) err_timeout <= 1'b1;
            else if (load_go)                                   err_timeout <= 1'b0;
            if (cfg_bad)      cfg_err <= 1'b1;
            else if (load_go) cfg_err <= 1'b0;
        end
    end

    // Completion pulse and frame counter, suppressed by abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= (state == DONE) && !abort;
            if (state == DONE && !abort) frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomized bench for frame_seq_ctrl on a 4x3 frame with a 16-cycle drain
// timeout. The reference model tracks accepted beats as a plain integer,
// keeps config as arrays and applies the frame rules directly.
module tb_frame_seq_ctrl;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int TOTAL = W * H;
    localparam int DT    = 16;
    localparam int FW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cfg_wr = 1'b0;
    logic [7:0] cfg_drv [8];
    logic [7:0] coe_00, coe_01, coe_02, coe_11, coe_12, coe_22, gth, gtl;
    logic busy, cfg_pending, frame_done, err_short, err_long, err_timeout, cfg_err;
    logic [FW-1:0] frame_cnt;

    frame_seq_ctrl_if bus ();

    frame_seq_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN_TIMEOUT(DT), .FCNT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_wr(cfg_wr),
        .cfg_coe_00(cfg_drv[0]), .cfg_coe_01(cfg_drv[1]), .cfg_coe_02(cfg_drv[2]),
        .cfg_coe_11(cfg_drv[3]), .cfg_coe_12(cfg_drv[4]), .cfg_coe_22(cfg_drv[5]),
        .cfg_gth(cfg_drv[6]), .cfg_gtl(cfg_drv[7]),
        .bus(bus),
        .coe_00_out(coe_00), .coe_01_out(coe_01), .coe_02_out(coe_02),
        .coe_11_out(coe_11), .coe_12_out(coe_12), .coe_22_out(coe_22),
        .gth_out(gth), .gtl_out(gtl),
        .busy(busy), .cfg_pending(cfg_pending), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long),
        .err_timeout(err_timeout), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] mdl_shadow [8];
    logic [7:0] mdl_active [8];
    logic [7:0] cfg_next   [8];
    bit mdl_pending, mdl_short, mdl_long, mdl_tout, mdl_cerr;
    int mdl_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] act_val(input int i);
        case (i)
            0: return coe_00;
            1: return coe_01;
            2: return coe_02;
            3: return coe_11;
            4: return coe_12;
            5: return coe_22;
            6: return gth;
            default: return gtl;
        endcase
    endfunction

    task automatic check_status(input string where);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_active%0d", where, i), 32'(act_val(i)), 32'(mdl_active[i]));
        check({where, "_pending"}, 32'(cfg_pending), 32'(mdl_pending));
        check({where, "_err_short"}, 32'(err_short), 32'(mdl_short));
        check({where, "_err_long"}, 32'(err_long), 32'(mdl_long));
        check({where, "_err_timeout"}, 32'(err_timeout), 32'(mdl_tout));
        check({where, "_cfg_err"}, 32'(cfg_err), 32'(mdl_cerr));
        check({where, "_frame_cnt"}, 32'(frame_cnt), 32'(mdl_fcnt % (1 << FW)));
    endtask

    // Present cfg_next for one cycle (caller deasserts) and update the model.
    task automatic drive_cfg();
        for (int i = 0; i < 8; i++) cfg_drv[i] = cfg_next[i];
        cfg_wr = 1'b1;
        if (cfg_next[6] >= cfg_next[7]) begin
            for (int i = 0; i < 8; i++) mdl_shadow[i] = cfg_next[i];
            mdl_pending = 1'b1;
        end else begin
            mdl_cerr = 1'b1;
        end
    endtask

    task automatic random_cfg();
        for (int i = 0; i < 8; i++) cfg_next[i] = 8'($urandom);
    endtask

    task automatic cfg_idle(input string tag);
        @(negedge clk);
        drive_cfg();
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
        check_status(tag);
    endtask

    task automatic start_frame(input bit cfg_in_load);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        if (mdl_pending) begin
            for (int i = 0; i < 8; i++) mdl_active[i] = mdl_shadow[i];
            mdl_pending = 1'b0;
        end
        {mdl_short, mdl_long, mdl_tout, mdl_cerr} = 4'b0;
        if (cfg_in_load) drive_cfg();
        #1;
        check("load_busy", 32'(busy), 32'd1);
        check("load_s_ready", 32'(bus.s_ready), 32'd0);
        check("load_m_valid", 32'(bus.m_valid), 32'd0);
    endtask

    // Stream one frame with random valid/ready. slast_at: beat number that
    // carries s_last (0 = never). stall_at: beats accepted before a 10-cycle
    // m_ready stall. abort_at: beats accepted before abort. cfg_at: cycle of
    // a config write.
    task automatic stream_frame(input int slast_at, input int stall_at, input int abort_at,
                                input int cfg_at, output bit aborted);
        int beats = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit fin = 1'b0;
        bit sv, mr, sl;
        aborted = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_status("stream_start");
            cfg_wr = 1'b0;
            if (stall_at > 0 && beats == stall_at && !stalled) begin
                stall_left = 10;
                stalled = 1'b1;
            end
            sv = ($urandom_range(0, 3) != 0);
            mr = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall_left > 0) stall_left--;
            sl = sv && (beats + 1 == slast_at);
            bus.s_data  = 8'($urandom);
            bus.s_valid = sv;
            bus.s_last  = sl;
            bus.m_ready = mr;
            start = 1'($urandom_range(0, 1));
            if (cyc == cfg_at) drive_cfg();
            abort = (abort_at > 0 && beats == abort_at && sv);
            #1;
            check("m_data", 32'(bus.m_data), 32'(bus.s_data));
            check("m_valid", 32'(bus.m_valid), 32'(sv));
            check("s_ready", 32'(bus.s_ready), 32'(mr));
            check($sformatf("m_last_beat%0d", beats + 1), 32'(bus.m_last),
                  32'(sv && (beats == TOTAL - 1 || sl)));
            if (abort) begin
                aborted = 1'b1;
                fin = 1'b1;
            end else if (sv && mr) begin
                beats++;
                if (sl && beats < TOTAL) mdl_short = 1'b1;
                if (beats == TOTAL && !sl) mdl_long = 1'b1;
                if (sl || beats == TOTAL) fin = 1'b1;
            end
        end
        if (!fin) check("stream_bound", 32'd0, 32'd1);
    endtask

    // One DRAIN cycle of core-side noise that never completes the handshake.
    task automatic core_noise();
        bus.core_out_last  = 1'($urandom_range(0, 1));
        bus.core_out_valid = 1'($urandom_range(0, 1));
        bus.core_out_ready = bus.core_out_last ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic drain_done(input int core_delay);
        for (int i = 0; i <= core_delay; i++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_wr = 1'b0;
            bus.s_valid = (i == 0);
            bus.m_ready = (i == 0);
            bus.s_last = 1'b0;
            if (i == core_delay) begin
                bus.core_out_valid = 1'b1;
                bus.core_out_ready = 1'b1;
                bus.core_out_last  = 1'b1;
            end else begin
                core_noise();
            end
            #1;
            if (i == 0) begin
                check("drain_s_ready", 32'(bus.s_ready), 32'd0);
                check("drain_m_valid", 32'(bus.m_valid), 32'd0);
            end
            check("drain_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        {bus.core_out_valid, bus.core_out_ready, bus.core_out_last} = 3'b0;
        #1;
        check("done_busy", 32'(busy), 32'd1);
        check("done_early_pulse", 32'(frame_done), 32'd0);
        @(negedge clk);
        #1;
        mdl_fcnt++;
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("done_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("frame_done_1cyc", 32'(frame_done), 32'd0);
        check_status("after_done");
    endtask

    task automatic drain_timeout();
        for (int i = 0; i < DT; i++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_wr = 1'b0;
            bus.s_valid = (i == 0);
            bus.m_ready = (i == 0);
            bus.s_last = 1'b0;
            core_noise();
            #1;
            check("tout_busy", 32'(busy), 32'd1);
            check("tout_flag_early", 32'(err_timeout), 32'd0);
        end
        @(negedge clk);
        {bus.core_out_valid, bus.core_out_ready, bus.core_out_last} = 3'b0;
        #1;
        mdl_tout = 1'b1;
        check("tout_idle", 32'(busy), 32'd0);
        check("tout_no_done", 32'(frame_done), 32'd0);
        check_status("after_timeout");
    endtask

    task automatic abort_follow();
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        cfg_wr = 1'b0;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s_ready", 32'(bus.s_ready), 32'd0);
        check("abort_m_valid", 32'(bus.m_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            #1;
            check("abort_no_done", 32'(frame_done), 32'd0);
        end
        check_status("after_abort");
    endtask

    bit ab;

    initial begin
        for (int i = 0; i < 8; i++) begin
            cfg_drv[i] = 8'h00;
            mdl_shadow[i] = (i < 6) ? 8'h04 : ((i == 6) ? 8'd5 : 8'd1);
            mdl_active[i] = mdl_shadow[i];
        end
        {mdl_pending, mdl_short, mdl_long, mdl_tout, mdl_cerr} = 5'b0;
        mdl_fcnt = 0;
        bus.s_data = 8'h00;
        {bus.s_valid, bus.s_last, bus.m_ready} = 3'b0;
        {bus.core_out_valid, bus.core_out_ready, bus.core_out_last} = 3'b0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_status("reset");
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_s_ready", 32'(bus.s_ready), 32'd0);
        check("reset_m_valid", 32'(bus.m_valid), 32'd0);

        // Clean frame with a valid config write mid-stream.
        cfg_next = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'd20, 8'd8};
        start_frame(1'b0);
        stream_frame(TOTAL, 0, 0, 4, ab);
        drain_done(5);

        // Rejected write: gth < gtl.
        cfg_next = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'd3, 8'd9};
        cfg_idle("bad_cfg");

        // start together with abort in IDLE stays idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_idle", 32'(busy), 32'd0);

        // Short frame with a 10-cycle m_ready stall.
        start_frame(1'b0);
        stream_frame(7, 5, 0, 0, ab);
        drain_done(5);

        // Long frame (no s_last) with stall, then drain timeout.
        start_frame(1'b0);
        stream_frame(0, 6, 0, 0, ab);
        drain_timeout();

        // Config written during LOAD stays pending; abort mid-stream.
        cfg_next = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'd40, 8'd40};
        start_frame(1'b1);
        stream_frame(TOTAL, 0, 5, 0, ab);
        check("abort_taken", 32'(ab), 32'd1);
        abort_follow();

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            random_cfg();
            start_frame(1'b0);
            stream_frame($urandom_range(1, TOTAL), $urandom_range(0, 8), 0,
                         $urandom_range(2, 6), ab);
            drain_done($urandom_range(0, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
Frame-level sequencer between the upstream byte stream and top_core. Gates the AXI-stream pixel flow one frame at a time, counts beats and generates the frame-end last. Applies new convolution coefficients and dual thresholds only between frames via shadow registers. Waits for the core's output last before reporting frame completion, with a drain timeout.

Parameters:
IMG_W, 1024, pixels per row
IMG_H, 1025, rows per frame (IMG_W*IMG_H = 1049600 beats)
DRAIN_TIMEOUT, 65536, max cycles in DRAIN waiting for core output last
FCNT_W, 16, frame counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  pulse: begin one frame (honoured only in IDLE)
abort  in  1  pulse: return to IDLE from any state
cfg_wr  in  1  write shadow config
cfg_coe_00/01/02/11/12/22  in  8 each  shadow coefficient values
cfg_gth, cfg_gtl  in  8 each  shadow thresholds
s_data  in  8  upstream pixel
s_valid  in  1  upstream valid
s_last  in  1  upstream frame-end marker
s_ready  out  1  upstream ready
m_data  out  8  to core axi_data_in
m_valid  out  1  to core input_axi_valid
m_last  out  1  to core input_axi_last
m_ready  in  1  from core input_axi_ready
core_out_valid, core_out_ready, core_out_last  in  1 each  monitored core output handshake
coe_00_out..coe_22_out  out  8 each  active coefficients to core
gth_out, gtl_out  out  8 each  active thresholds to core
busy  out  1  state != IDLE
cfg_pending  out  1  shadow holds unapplied config
frame_done  out  1  1-cycle pulse per completed frame
frame_cnt  out  FCNT_W  completed frames, wraps
err_short, err_long, err_timeout, cfg_err  out  1 each  sticky error flags

Behaviour:
- Reset: state IDLE; coe_*_out = 8'h04; gth_out = 5; gtl_out = 1; shadow equals active; cfg_pending=0; counters, frame_cnt, all flags, frame_done = 0.
- States: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: s_ready=0, m_valid=0. start -> LOAD.
- LOAD (1 cycle): if cfg_pending, copy shadow to active outputs and clear cfg_pending. Clear col/row counters. -> STREAM.
- STREAM: combinational pass-through, zero latency: m_data=s_data, m_valid=s_valid, s_ready=m_ready. A beat is s_valid&m_ready. col counts 0..IMG_W-1, wraps and increments row.
- m_last = s_valid & (col==IMG_W-1) & (row==IMG_H-1). Final beat -> DRAIN. If s_last is not set on the final beat, set err_long.
- s_last on an earlier beat: set err_short, force m_last=1 on that beat, -> DRAIN.
- DRAIN: s_ready=0, m_valid=0. A timeout counter starts at 0.
  - core_out_valid & core_out_ready & core_out_last -> DONE.
  - Counter reaching DRAIN_TIMEOUT-1 -> set err_timeout, -> IDLE with no done pulse and no frame_cnt increment.
- DONE (1 cycle): frame_done=1, frame_cnt+1 (wrap at 2^FCNT_W). -> IDLE.
- cfg_wr in any state: if cfg_gth >= cfg_gtl, load shadow and set cfg_pending. Otherwise discard the write and set cfg_err.
- cfg_wr in the same cycle as LOAD: LOAD applies the pre-write shadow; the new write stays pending for the next frame.
- Active outputs never change outside LOAD.
- abort: highest priority, synchronous. Next state IDLE; counters cleared; no frame_done. Shadow, active config and flags are kept. s_ready/m_valid drop combinationally in the next cycle.
- start outside IDLE is ignored. start and abort together: abort wins.
- Sticky flags clear only on reset or on LOAD.

Test Plan:
- IMG_W=4, IMG_H=3, start, 12 beats with s_last on beat 12, core_out_last 5 cycles later -> m_last only on beat 12; frame_done one cycle after DONE entry; frame_cnt=1; no error flags.
- cfg_wr coe=8'h10, gth=20, gtl=8 during STREAM -> coe_*_out stay 8'h04, gth/gtl stay 5/1 until next LOAD, then become 8'h10/20/8; cfg_pending drops to 0.
- cfg_wr gth=3, gtl=9 -> cfg_err=1, shadow unchanged, cfg_pending unchanged.
- s_last on beat 7 of 12 -> err_short=1, m_last=1 on beat 7, s_ready=0 afterwards.
- m_ready held low 10 cycles mid-frame -> counters frozen, no beat lost; total beats still 12.
- DRAIN_TIMEOUT=16 and core_out_last never asserted -> err_timeout=1 after 16 cycles, IDLE, frame_cnt unchanged. Separately, abort mid-STREAM -> IDLE next cycle, no frame_done pulse.
